// File: rtl/rx_block_type_tracker.sv
// Multi-lane 128b/130b sync-header decoder: per-lane block type, header error pulses,
// per-lane lock FSM, cross-lane type-mismatch pulse and a saturating error counter.
module rx_block_type_tracker #(
    parameter int LANES        = 4,
    parameter int LOCK_CNT     = 4,
    parameter int ERR_THRESH   = 2,
    parameter int CNT_W        = 8,
    parameter int INVALID_HOLD = 0
) (
    input  logic                 CLK,
    input  logic                 RST_L,
    input  logic [2*LANES-1:0]   RX_Sync_Header,
    input  logic [LANES-1:0]     RX_Start_Block,
    input  logic                 Err_Count_Clr,
    output logic [LANES-1:0]     Block_Type,
    output logic [LANES-1:0]     Sync_Hdr_Err,
    output logic [LANES-1:0]     Lane_Locked,
    output logic                 Lane_Mismatch,
    output logic [CNT_W-1:0]     Err_Count
);

    localparam int MAX_RUN = (LOCK_CNT > ERR_THRESH) ? LOCK_CNT : ERR_THRESH;
    localparam int RUN_W   = $clog2(MAX_RUN) + 1;
    localparam int POP_W   = $clog2(LANES + 1);
    localparam logic [RUN_W-1:0] LOCK_TGT = RUN_W'(LOCK_CNT);
    localparam logic [RUN_W-1:0] ERR_TGT  = RUN_W'(ERR_THRESH);

    typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

    logic [LANES-1:0] dec_type;
    logic [LANES-1:0] hdr_valid;
    logic [LANES-1:0] hdr_invalid;
    logic [LANES-1:0] mm_qual;
    logic             any_os;
    logic             any_data;

    function automatic logic [POP_W-1:0] popcount(input logic [LANES-1:0] v);
        logic [POP_W-1:0] acc;
        acc = '0;
        for (int k = 0; k < LANES; k++) begin
            acc = acc + POP_W'(v[k]);
        end
        return acc;
    endfunction

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                                 input logic [POP_W-1:0] b);
        logic [CNT_W+POP_W-1:0] s;
        s = {{POP_W{1'b0}}, a} + {{CNT_W{1'b0}}, b};
        if (s > {{POP_W{1'b0}}, {CNT_W{1'b1}}}) begin
            return {CNT_W{1'b1}};
        end
        return s[CNT_W-1:0];
    endfunction

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [1:0]       hdr;
        logic             is_data;
        logic             is_os;
        logic             held_type;
        logic             locked;
        lock_state_t      state;
        logic [RUN_W-1:0] run_cnt;
        logic [RUN_W-1:0] run_nxt;

        assign hdr            = RX_Sync_Header[2*i +: 2];
        assign is_data        = (hdr == 2'b01);
        assign is_os          = (hdr == 2'b10);
        assign hdr_valid[i]   = RX_Start_Block[i] & (is_data | is_os);
        assign hdr_invalid[i] = RX_Start_Block[i] & ~(is_data | is_os);
        assign run_nxt        = run_cnt + RUN_W'(1);
        assign Lane_Locked[i] = locked;

        // Invalid headers either decode as Data or keep the previous type.
        assign dec_type[i] = !RX_Start_Block[i] ? held_type :
                             is_os              ? 1'b1 :
                             is_data            ? 1'b0 :
                             (INVALID_HOLD != 0) ? held_type : 1'b0;

        // Only start cycles advance the held type and the lock FSM.
        always_ff @(posedge CLK or negedge RST_L) begin
            if (!RST_L) begin
                held_type <= 1'b0;
                state     <= UNLOCKED;
                locked    <= 1'b0;
                run_cnt   <= '0;
            end else if (RX_Start_Block[i]) begin
                held_type <= dec_type[i];
                case (state)
                    UNLOCKED: begin
                        if (!hdr_valid[i]) begin
                            run_cnt <= '0;
                        end else if (run_nxt == LOCK_TGT) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_nxt;
                        end
                    end
                    LOCKED: begin
                        if (hdr_valid[i]) begin
                            run_cnt <= '0;
                        end else if (run_nxt == ERR_TGT) begin
                            state   <= UNLOCKED;
                            locked  <= 1'b0;
                            run_cnt <= '0;
                        end else begin
                            run_cnt <= run_nxt;
                        end
                    end
                    default: begin
                        state   <= UNLOCKED;
                        locked  <= 1'b0;
                        run_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign Block_Type = dec_type;

    // Only locked lanes with a valid header this cycle vote on the type.
    assign mm_qual  = Lane_Locked & hdr_valid;
    assign any_os   = |(mm_qual & dec_type);
    assign any_data = |(mm_qual & ~dec_type);

    always_ff @(posedge CLK or negedge RST_L) begin
        if (!RST_L) begin
            Sync_Hdr_Err  <= '0;
            Lane_Mismatch <= 1'b0;
            Err_Count     <= '0;
        end else begin
            Sync_Hdr_Err  <= hdr_invalid;
            Lane_Mismatch <= any_os & any_data;
            Err_Count     <= Err_Count_Clr ? '0 : sat_add(Err_Count, popcount(hdr_invalid));
        end
    end

endmodule
